fetch_sequencer: RTL and testbench

Parametrised boot-and-fetch front end for the pipelined core. Loads a fixed-length program image from the BIOS stream into instruction memory over a valid/ready handshake, then switches to RUN, where it owns the PC, drives instruction-memory reads, and holds the IF/ID register. In RUN it adds stall, branch-redirect flush and re-boot on request.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Boot-and-fetch front end: streams a fixed-length BIOS image into instruction
// memory, then owns the PC and the IF/ID register with stall, redirect and re-boot.
module fetch_sequencer #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                BOOT_WORDS = 16,
   parameter logic [ADDR_W-1:0] BOOT_BASE  = '0,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(1)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              boot_start,
   input  logic [DATA_W-1:0]                 bios_data,
   input  logic                              bios_valid,
   output logic                              bios_ready,
   output logic [ADDR_W-1:0]                 imem_addr,
   output logic [DATA_W-1:0]                 imem_wdata,
   output logic                              imem_we,
   output logic                              imem_oe,
   input  logic [DATA_W-1:0]                 imem_rdata,
   input  logic                              stall,
   input  logic                              redirect,
   input  logic [ADDR_W-1:0]                 redirect_pc,
   output logic                              fetch_valid,
   output logic [DATA_W-1:0]                 fetch_instr,
   output logic [ADDR_W-1:0]                 fetch_pcpp,
   output logic                              on_bios,
   output logic                              boot_done,
   output logic [$clog2(BOOT_WORDS+1)-1:0]   boot_count
);

   localparam int CW = $clog2(BOOT_WORDS + 1);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [CW-1:0]       count_r, count_s;
   logic [ADDR_W-1:0]   pc_r, pc_s;
   logic                fetch_valid_r, fetch_valid_s;
   logic [DATA_W-1:0]   fetch_instr_r, fetch_instr_s;
   logic [ADDR_W-1:0]   fetch_pcpp_r, fetch_pcpp_s;
   logic                boot_done_r, boot_done_s;
   logic                last_word_s;

   assign last_word_s = (count_r == CW'(BOOT_WORDS - 1));

   // State, PC and IF/ID registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= BOOT;
         count_r       <= '0;
         pc_r          <= RESET_PC;
         fetch_valid_r <= 1'b0;
         fetch_instr_r <= '0;
         fetch_pcpp_r  <= '0;
         boot_done_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         count_r       <= count_s;
         pc_r          <= pc_s;
         fetch_valid_r <= fetch_valid_s;
         fetch_instr_r <= fetch_instr_s;
         fetch_pcpp_r  <= fetch_pcpp_s;
         boot_done_r   <= boot_done_s;
      end
   end

   // Next-state and memory-port decode; boot_start outranks everything in both states
   always_comb begin
      state_s       = state_r;
      count_s       = count_r;
      pc_s          = pc_r;
      fetch_valid_s = fetch_valid_r;
      fetch_instr_s = fetch_instr_r;
      fetch_pcpp_s  = fetch_pcpp_r;
      boot_done_s   = 1'b0;
      bios_ready    = 1'b0;
      on_bios       = 1'b0;
      imem_oe       = 1'b0;
      imem_we       = 1'b0;
      imem_addr     = pc_r;
      imem_wdata    = '0;
      case (state_r)
         BOOT: begin
            bios_ready = 1'b1;
            on_bios    = 1'b1;
            imem_we    = bios_valid;
            imem_addr  = BOOT_BASE + ADDR_W'(count_r);
            imem_wdata = bios_data;
            // A word arriving with boot_start is still written but not counted
            if (boot_start) begin
               count_s = '0;
            end else if (bios_valid) begin
               count_s = count_r + CW'(1);
               if (last_word_s) begin
                  state_s     = RUN;
                  pc_s        = RESET_PC;
                  boot_done_s = 1'b1;
               end else begin
                  state_s = BOOT;
               end
            end else begin
               count_s = count_r;
            end
         end
         RUN: begin
            imem_oe   = 1'b1;
            imem_addr = pc_r;
            if (boot_start) begin
               state_s       = BOOT;
               count_s       = '0;
               fetch_valid_s = 1'b0;
               fetch_instr_s = '0;
            end else if (redirect) begin
               pc_s          = redirect_pc;
               fetch_valid_s = 1'b0;
               fetch_instr_s = '0;
            end else if (stall) begin
               pc_s = pc_r;
            end else begin
               fetch_instr_s = imem_rdata;
               fetch_pcpp_s  = pc_r + PC_STEP;
               fetch_valid_s = 1'b1;
               pc_s          = pc_r + PC_STEP;
            end
         end
         default: begin
            state_s = BOOT;
            count_s = '0;
         end
      endcase
   end

   assign fetch_valid = fetch_valid_r;
   assign fetch_instr = fetch_instr_r;
   assign fetch_pcpp  = fetch_pcpp_r;
   assign boot_done   = boot_done_r;
   assign boot_count  = count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a per-edge reference model pushes expected
// state into a queue and a negedge monitor pops and compares against the DUT.
module tb_fetch_sequencer;

   localparam int             AW    = 8;
   localparam int             DW    = 32;
   localparam int             BW    = 16;
   localparam int             ASIZE = 256;
   localparam logic [AW-1:0]  BASE  = 8'h00;
   localparam logic [AW-1:0]  RPC   = 8'h00;
   localparam logic [AW-1:0]  STEP  = 8'h01;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            reset, boot_start, bios_valid, stall, redirect;
   logic [DW-1:0]   bios_data;
   logic [AW-1:0]   redirect_pc;
   logic            bios_ready, imem_we, imem_oe, fetch_valid, on_bios, boot_done;
   logic [AW-1:0]   imem_addr, fetch_pcpp;
   logic [DW-1:0]   imem_wdata, imem_rdata, fetch_instr;
   logic [4:0]      boot_count;

   fetch_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .BOOT_WORDS(BW),
      .BOOT_BASE(BASE), .RESET_PC(RPC), .PC_STEP(STEP)
   ) dut (
      .clock(clock), .reset(reset), .boot_start(boot_start),
      .bios_data(bios_data), .bios_valid(bios_valid), .bios_ready(bios_ready),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
      .imem_oe(imem_oe), .imem_rdata(imem_rdata), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .fetch_valid(fetch_valid),
      .fetch_instr(fetch_instr), .fetch_pcpp(fetch_pcpp), .on_bios(on_bios),
      .boot_done(boot_done), .boot_count(boot_count)
   );

   // Instruction memory written only by the DUT
   logic [DW-1:0] mem [0:ASIZE-1];
   assign imem_rdata = mem[imem_addr];
   always @(posedge clock) begin
      if (imem_we === 1'b1) mem[imem_addr] <= imem_wdata;
   end

   typedef struct {
      bit          booting;
      int          words;
      int          pc;
      bit          fv;
      logic [31:0] fi;
      int          fp;
      bit          done;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_mem [0:ASIZE-1];
   bit          m_booting;
   int          m_words, m_pc, m_fp;
   bit          m_fv, m_done;
   logic [31:0] m_fi;
   int          checks = 0;
   int          errors = 0;

   task automatic model_step();
      exp_t e;
      if (!reset) begin
         m_booting = 1'b1; m_words = 0; m_pc = int'(RPC);
         m_fv = 1'b0; m_fi = 32'h0; m_fp = 0; m_done = 1'b0;
      end else if (m_booting) begin
         m_done = 1'b0;
         if (bios_valid) m_mem[(int'(BASE) + m_words) % ASIZE] = bios_data;
         if (boot_start) begin
            m_words = 0;
         end else if (bios_valid) begin
            m_words = m_words + 1;
            if (m_words == BW) begin
               m_booting = 1'b0; m_pc = int'(RPC); m_done = 1'b1;
            end
         end
      end else begin
         m_done = 1'b0;
         if (boot_start) begin
            m_booting = 1'b1; m_words = 0; m_fv = 1'b0; m_fi = 32'h0;
         end else if (redirect) begin
            m_pc = int'(redirect_pc); m_fv = 1'b0; m_fi = 32'h0;
         end else if (!stall) begin
            m_fi = m_mem[m_pc];
            m_fp = (m_pc + int'(STEP)) % ASIZE;
            m_fv = 1'b1;
            m_pc = m_fp;
         end
      end
      e.booting = m_booting; e.words = m_words; e.pc = m_pc;
      e.fv = m_fv; e.fi = m_fi; e.fp = m_fp; e.done = m_done;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks = checks + 1;
      if (act !== expv) begin
         errors = errors + 1;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, expv);
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   // Monitor: compare every presented cycle against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("fetch_valid", 64'(fetch_valid), 64'(e.fv));
            chk("fetch_instr", 64'(fetch_instr), 64'(e.fi));
            chk("fetch_pcpp",  64'(fetch_pcpp),  64'(e.fp));
            chk("boot_done",   64'(boot_done),   64'(e.done));
            chk("boot_count",  64'(boot_count),  64'(e.words));
            chk("on_bios",     64'(on_bios),     64'(e.booting));
            chk("bios_ready",  64'(bios_ready),  64'(e.booting));
            chk("imem_oe",     64'(imem_oe),     64'(!e.booting));
            chk("imem_we",     64'(imem_we),     64'(e.booting & bios_valid));
            if (e.booting) begin
               chk("imem_addr_boot", 64'(imem_addr), 64'((int'(BASE) + e.words) % ASIZE));
               chk("imem_wdata",     64'(imem_wdata), 64'(bios_data));
            end else begin
               chk("imem_addr_run",  64'(imem_addr), 64'(e.pc));
            end
         end
      end
   end

   task automatic step(input logic r, input logic bs, input logic bv, input logic [31:0] bd,
                       input logic st, input logic rd, input logic [7:0] rp);
      reset = r; boot_start = bs; bios_valid = bv; bios_data = bd;
      stall = st; redirect = rd; redirect_pc = rp;
      @(posedge clock);
      #2;
   endtask

   initial begin
      for (int i = 0; i < ASIZE; i++) begin
         mem[i]   = 32'hDEAD_0000 | 32'(i);
         m_mem[i] = 32'hDEAD_0000 | 32'(i);
      end
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < BW; i++) step(1'b1, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 8'h00);
      repeat (5) step(1'b1, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, 8'h00);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h03);
      repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hFE);
      repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      // Re-boot with bios_valid toggling every cycle
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 2 * BW; i++)
         step(1'b1, 1'b0, (i % 2) == 0, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 8'h00);
      repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      // boot_start while booting, with a word offered on the same edge
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b1, 32'hC0DE_0000, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < BW; i++) step(1'b1, 1'b0, 1'b1, 32'hC100_0000 + 32'(i), 1'b1, 1'b1, 8'h07);
      repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      // Reset in the middle of a boot
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < BW; i++) step(1'b1, 1'b0, 1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 8'h00);
      repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      // Random traffic
      for (int i = 0; i < 300; i++)
         step(1'b1, $urandom_range(99, 0) < 2, $urandom_range(1, 0) == 1, $urandom,
              $urandom_range(99, 0) < 25, $urandom_range(99, 0) < 10, 8'($urandom));
      repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
